// File: rtl/dec_digit_emitter.sv
// Binary-to-decimal character emitter: one div10 step per cycle into a digit
// buffer, then the digits are streamed MSD first on a valid/ready/last port.

module div10 (
    input  logic [31:0] dividend,
    output logic [31:0] quotient,
    output logic [3:0]  remainder
);
    // x * ceil(2^35 / 10) >> 35 gives the exact floor(x / 10) for every 32-bit x
    always_comb begin
        quotient  = 32'((64'(dividend) * 64'hCCCC_CCCD) >> 35);
        remainder = dividend[3:0] - 4'(quotient[3:0] * 4'd10);
    end
endmodule

module dec_digit_emitter #(
    parameter bit SIGNED    = 1'b0,
    parameter bit ASCII_OUT = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CONV, EMIT} state_t;

    state_t      state, state_nxt;
    logic [31:0] work;
    logic [31:0] quot;
    logic [3:0]  rem;
    logic [3:0]  digits [10];
    logic [3:0]  count;
    logic [3:0]  ptr;
    logic        neg;
    logic        sign_sent;
    logic        in_fire;
    logic        out_fire;
    logic        sign_phase;
    logic        in_neg;

    div10 u_div10 (
        .dividend  (work),
        .quotient  (quot),
        .remainder (rem)
    );

    // Outputs decode purely from registered state, so they hold while stalled.
    always_comb begin
        in_ready   = (state == IDLE);
        busy       = !in_ready;
        out_valid  = (state == EMIT);
        sign_phase = neg && !sign_sent;
        in_fire    = in_valid && in_ready;
        out_fire   = out_valid && out_ready;
        in_neg     = SIGNED && in_data[31];
        out_data   = '0;
        out_last   = 1'b0;
        if (out_valid) begin
            if (sign_phase) begin
                out_data = 8'h2D;
            end else begin
                out_data = ASCII_OUT ? (8'h30 + {4'h0, digits[ptr]}) : {4'h0, digits[ptr]};
                out_last = (ptr == 4'd0);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_fire) state_nxt = CONV;
            CONV:    if (quot == '0) state_nxt = EMIT;
            EMIT:    if (out_fire && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            work      <= '0;
            digits    <= '{default: '0};
            count     <= '0;
            ptr       <= '0;
            neg       <= 1'b0;
            sign_sent <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_fire) begin
                        work      <= in_neg ? -in_data : in_data;
                        neg       <= in_neg;
                        count     <= '0;
                        sign_sent <= 1'b0;
                    end
                end
                CONV: begin
                    digits[count] <= rem;
                    count         <= count + 4'd1;
                    work          <= quot;
                    if (quot == '0) ptr <= count;
                end
                EMIT: begin
                    if (out_fire) begin
                        if (sign_phase) sign_sent <= 1'b1;
                        else            ptr       <= ptr - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
